shift_exec_stage: RTL and testbench

//  Two-stage pipelined shift execution unit for the RV32 ALU. Accepts shift ops from

---
 rtl/shift_pkg.sv | 25 ++
 rtl/shift_exec_stage_if.sv | 32 +++
 rtl/shift_left32.sv | 20 ++
 rtl/shift_exec_stage.sv | 161 ++++++++++++++++
 tb/tb_shift_exec_stage.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared types and helpers for the shift execution stage.
// Op encodings, datapath width and the bit-reversal helper used for right shifts.
package shift_pkg;

  localparam int SH_XLEN  = 32;
  localparam int SH_TAG_W = 5;

  typedef enum logic [2:0] {
    SHOP_SLL = 3'b000,
    SHOP_SRL = 3'b001,
    SHOP_SRA = 3'b010,
    SHOP_ROL = 3'b011,
    SHOP_ROR = 3'b100
  } shop_t;

  function automatic logic [SH_XLEN-1:0] rev32(input logic [SH_XLEN-1:0] v);
    logic [SH_XLEN-1:0] r;
    r = {SH_XLEN{1'b0}};
    for (int i = 0; i < SH_XLEN; i++) begin
      r[i] = v[SH_XLEN-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_exec_stage_if.sv
// Issue-side and writeback-side handshake bundle for shift_exec_stage.
// Op codes travel as raw 3-bit values so unsupported encodings can be presented.
interface shift_exec_stage_if
  import shift_pkg::*;
#(
  parameter int TAG_W = SH_TAG_W
);

  logic                in_valid;
  logic                in_ready;
  logic [2:0]          in_op;
  logic [SH_XLEN-1:0]  in_a;
  logic [4:0]          in_shamt;
  logic [TAG_W-1:0]    in_tag;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [SH_XLEN-1:0]  out_res;
  logic [TAG_W-1:0]    out_tag;
  logic                out_illegal;

  modport master (
    output in_valid, in_op, in_a, in_shamt, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_res, out_tag, out_illegal
  );

  modport slave (
    input  in_valid, in_op, in_a, in_shamt, in_tag, flush, out_ready,
    output in_ready, out_valid, out_res, out_tag, out_illegal
  );

endinterface

// File: rtl/shift_left32.sv
// 32-bit logarithmic left barrel shifter, zero fill.
// Shared by all shift/rotate flavours of the execution stage.
module shift_left32 (
  input  logic [31:0] a,
  input  logic [4:0]  shamt,
  output logic [31:0] y
);

  logic [31:0] st1_s;
  logic [31:0] st2_s;
  logic [31:0] st4_s;
  logic [31:0] st8_s;

  assign st1_s = shamt[0] ? {a[30:0],     1'b0}  : a;
  assign st2_s = shamt[1] ? {st1_s[29:0], 2'b00} : st1_s;
  assign st4_s = shamt[2] ? {st2_s[27:0], 4'h0}  : st2_s;
  assign st8_s = shamt[3] ? {st4_s[23:0], 8'h00} : st4_s;
  assign y     = shamt[4] ? {st8_s[15:0], 16'h0000} : st8_s;

endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage pipelined RV32 shift unit (SLL/SRL/SRA) with valid/ready, flush and backpressure.
// Build option SHIFT_ROTATE_EN adds ROL/ROR; without it those codes report out_illegal.
module shift_exec_stage
  import shift_pkg::*;
#(
  parameter int XLEN  = SH_XLEN,
  parameter int TAG_W = SH_TAG_W
) (
  input  logic               clk,
  input  logic               rst,
  shift_exec_stage_if.slave  bus
);

  logic              s1_valid_r;
  logic [2:0]        s1_op_r;
  logic [XLEN-1:0]   s1_a_r;
  logic [4:0]        s1_shamt_r;
  logic [TAG_W-1:0]  s1_tag_r;

  logic              s2_valid_r;
  logic [XLEN-1:0]   s2_res_r;
  logic [TAG_W-1:0]  s2_tag_r;
  logic              s2_illegal_r;

  logic              s2_adv_s;
  logic              s1_adv_s;
  logic              in_ready_s;
  logic              accept_s;
  logic              move_s;

  logic [XLEN-1:0]   a_rev_s;
  logic [XLEN-1:0]   l0_in_s;
  logic [XLEN-1:0]   l0_out_s;
  logic [XLEN-1:0]   res_s;
  logic              illegal_s;

  assign s2_adv_s   = !s2_valid_r || bus.out_ready;
  assign s1_adv_s   = !s1_valid_r || s2_adv_s;
  // A flush kills everything in flight, so the input can always be (and is) dropped then.
  assign in_ready_s = s1_adv_s || bus.flush;
  assign accept_s   = bus.in_valid && in_ready_s && !bus.flush;
  assign move_s     = s1_valid_r && s2_adv_s;

  assign a_rev_s = rev32(s1_a_r);

  // Left-type ops feed the operand straight in; right-type ops shift the reversed operand.
  always_comb begin
    l0_in_s = a_rev_s;
    case (s1_op_r)
      SHOP_SLL: l0_in_s = s1_a_r;
      SHOP_ROL: l0_in_s = s1_a_r;
      default:  l0_in_s = a_rev_s;
    endcase
  end

  shift_left32 u_shl0 (
    .a     (l0_in_s),
    .shamt (s1_shamt_r),
    .y     (l0_out_s)
  );

`ifdef SHIFT_ROTATE_EN
  logic [XLEN-1:0] l1_in_s;
  logic [XLEN-1:0] l1_out_s;
  logic [4:0]      l1_shamt_s;

  // Complementary amount (32 - s) mod 32; s = 0 gives a zero shift and the OR yields a.
  assign l1_shamt_s = 5'd0 - s1_shamt_r;

  // Second shifter supplies the wrapped-around half of a rotate.
  always_comb begin
    l1_in_s = s1_a_r;
    if (s1_op_r == SHOP_ROL) begin
      l1_in_s = a_rev_s;
    end else begin
      l1_in_s = s1_a_r;
    end
  end

  shift_left32 u_shl1 (
    .a     (l1_in_s),
    .shamt (l1_shamt_s),
    .y     (l1_out_s)
  );
`endif

  // Result select; unsupported op codes produce zero and flag illegal.
  always_comb begin
    res_s     = {XLEN{1'b0}};
    illegal_s = 1'b0;
    case (s1_op_r)
      SHOP_SLL: res_s = l0_out_s;
      SHOP_SRL: res_s = rev32(l0_out_s);
      SHOP_SRA: res_s = rev32(l0_out_s) |
                        (s1_a_r[XLEN-1] ? ~({XLEN{1'b1}} >> s1_shamt_r) : {XLEN{1'b0}});
`ifdef SHIFT_ROTATE_EN
      SHOP_ROL: res_s = l0_out_s | rev32(l1_out_s);
      SHOP_ROR: res_s = rev32(l0_out_s) | l1_out_s;
`endif
      default: begin
        res_s     = {XLEN{1'b0}};
        illegal_s = 1'b1;
      end
    endcase
  end

  // S1 operand register: refills on accept, empties when it advances with nothing new.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_op_r    <= 3'b000;
      s1_a_r     <= {XLEN{1'b0}};
      s1_shamt_r <= 5'd0;
      s1_tag_r   <= {TAG_W{1'b0}};
    end else begin
      if (bus.flush) begin
        s1_valid_r <= 1'b0;
      end else if (s1_adv_s) begin
        s1_valid_r <= accept_s;
      end else begin
        s1_valid_r <= s1_valid_r;
      end
      if (accept_s) begin
        s1_op_r    <= bus.in_op;
        s1_a_r     <= bus.in_a;
        s1_shamt_r <= bus.in_shamt;
        s1_tag_r   <= bus.in_tag;
      end
    end
  end

  // S2 result register: holds while writeback stalls, so out_* stay stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_r   <= 1'b0;
      s2_res_r     <= {XLEN{1'b0}};
      s2_tag_r     <= {TAG_W{1'b0}};
      s2_illegal_r <= 1'b0;
    end else begin
      if (bus.flush) begin
        s2_valid_r <= 1'b0;
      end else if (s2_adv_s) begin
        s2_valid_r <= s1_valid_r;
      end else begin
        s2_valid_r <= s2_valid_r;
      end
      if (move_s) begin
        s2_res_r     <= res_s;
        s2_tag_r     <= s1_tag_r;
        s2_illegal_r <= illegal_s;
      end
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = s2_valid_r;
  assign bus.out_res     = s2_res_r;
  assign bus.out_tag     = s2_tag_r;
  assign bus.out_illegal = s2_illegal_r;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed self-checking bench for shift_exec_stage (honours SHIFT_ROTATE_EN for expectations).
// Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
module tb_shift_exec_stage;
  import shift_pkg::*;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [4:0]  sh;
    logic [4:0]  tag;
    logic [31:0] res;
    logic        ill;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs [14];

  always #5 clk = ~clk;

  shift_exec_stage_if #(.TAG_W(SH_TAG_W)) bus ();

  shift_exec_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, input logic [4:0] sh,
                              input logic [4:0] tag, input logic [31:0] res, input logic ill);
    vec_t v;
    v.op = op; v.a = a; v.sh = sh; v.tag = tag; v.res = res; v.ill = ill;
    return v;
  endfunction

  task automatic present(input vec_t v);
    bus.in_valid = 1'b1;
    bus.in_op    = v.op;
    bus.in_a     = v.a;
    bus.in_shamt = v.sh;
    bus.in_tag   = v.tag;
  endtask

  // Streams vecs[first +: n] with writeback stalled for stall_len cycles from cycle stall_at.
  task automatic run_stream(input int first, input int n, input int stall_at, input int stall_len);
    int idx  = first;
    int oidx = first;
    int cyc  = 0;
    bit ready_drop = 1'b0;
    while (oidx < first + n && cyc < 200) begin
      @(posedge clk); #1;
      if (idx < first + n) present(vecs[idx]);
      else bus.in_valid = 1'b0;
      bus.out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      @(negedge clk);
      if (bus.in_valid && !bus.in_ready) ready_drop = 1'b1;
      if (bus.out_valid) begin
        if (oidx < first + n) begin
          check($sformatf("res[%0d]", oidx), bus.out_res, vecs[oidx].res);
          check($sformatf("tag[%0d]", oidx), 32'(bus.out_tag), 32'(vecs[oidx].tag));
          check($sformatf("ill[%0d]", oidx), 32'(bus.out_illegal), 32'(vecs[oidx].ill));
          if (bus.out_ready) oidx++;
        end else begin
          check("extra_output", 32'd1, 32'd0);
        end
      end
      if (bus.in_valid && bus.in_ready) idx++;
      cyc++;
    end
    check("stream_count", 32'(oidx - first), 32'(n));
    if (stall_len > 0) check("stall_in_ready_drop", 32'(ready_drop), 32'd1);
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  initial begin
    vecs[0]  = mk(3'b000, 32'h0000_0001, 5'd31, 5'd3,  32'h8000_0000, 1'b0);
    vecs[1]  = mk(3'b010, 32'hF000_0000, 5'd4,  5'd4,  32'hFF00_0000, 1'b0);
    vecs[2]  = mk(3'b001, 32'hF000_0000, 5'd4,  5'd5,  32'h0F00_0000, 1'b0);
    vecs[3]  = mk(3'b010, 32'hF000_0000, 5'd0,  5'd6,  32'hF000_0000, 1'b0);
    vecs[4]  = mk(3'b010, 32'h8000_0000, 5'd31, 5'd7,  32'hFFFF_FFFF, 1'b0);
    vecs[5]  = mk(3'b001, 32'h8000_0000, 5'd31, 5'd8,  32'h0000_0001, 1'b0);
    vecs[6]  = mk(3'b000, 32'h1234_5678, 5'd4,  5'd9,  32'h2345_6780, 1'b0);
    vecs[7]  = mk(3'b010, 32'h7FFF_FFFF, 5'd30, 5'd10, 32'h0000_0001, 1'b0);
    vecs[8]  = mk(3'b001, 32'hDEAD_BEEF, 5'd8,  5'd11, 32'h00DE_ADBE, 1'b0);
    vecs[9]  = mk(3'b111, 32'h1234_5678, 5'd3,  5'd12, 32'h0000_0000, 1'b1);
`ifdef SHIFT_ROTATE_EN
    vecs[10] = mk(3'b011, 32'h8000_0001, 5'd1,  5'd13, 32'h0000_0003, 1'b0);
    vecs[11] = mk(3'b100, 32'h8000_0001, 5'd1,  5'd14, 32'hC000_0000, 1'b0);
    vecs[12] = mk(3'b011, 32'h1234_5678, 5'd0,  5'd15, 32'h1234_5678, 1'b0);
`else
    vecs[10] = mk(3'b011, 32'h8000_0001, 5'd1,  5'd13, 32'h0000_0000, 1'b1);
    vecs[11] = mk(3'b100, 32'h8000_0001, 5'd1,  5'd14, 32'h0000_0000, 1'b1);
    vecs[12] = mk(3'b011, 32'h1234_5678, 5'd0,  5'd15, 32'h0000_0000, 1'b1);
`endif
    vecs[13] = mk(3'b000, 32'hFFFF_FFFF, 5'd0,  5'd16, 32'hFFFF_FFFF, 1'b0);

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_op = 3'b000; bus.in_a = 32'h0; bus.in_shamt = 5'd0;
    bus.in_tag = 5'd0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_res", bus.out_res, 32'h0);
    check("rst_out_tag", 32'(bus.out_tag), 32'd0);
    check("rst_out_illegal", 32'(bus.out_illegal), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk); rst = 1'b0;

    // Latency: accept edge, then result visible after the second edge.
    @(posedge clk); #1; present(vecs[0]);
    @(negedge clk); check("lat_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1; bus.in_valid = 1'b0;
    @(negedge clk); check("lat_valid_c1", 32'(bus.out_valid), 32'd0);
    @(negedge clk); check("lat_valid_c2", 32'(bus.out_valid), 32'd1);
    check("lat_res", bus.out_res, 32'h8000_0000);
    check("lat_tag", 32'(bus.out_tag), 32'd3);
    @(negedge clk); check("lat_drained", 32'(bus.out_valid), 32'd0);

    run_stream(0, 8, 3, 3);
    run_stream(8, 6, 1000, 0);

    // Flush with both stages full and a new op presented.
    @(posedge clk); #1; bus.out_ready = 1'b0; present(vecs[6]);
    @(posedge clk); #1; present(vecs[7]);
    @(posedge clk); #1; present(vecs[8]);
    #1;
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    check("full_out_valid", 32'(bus.out_valid), 32'd1);
    check("full_out_res", bus.out_res, vecs[6].res);
    bus.flush = 1'b1;
    #1; check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1; bus.flush = 1'b0; bus.out_ready = 1'b1; present(vecs[1]);
    #1; check("post_flush_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1; bus.in_valid = 1'b0;
    #1; check("post_flush_c1", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #2;
    check("post_flush_c2", 32'(bus.out_valid), 32'd1);
    check("post_flush_res", bus.out_res, vecs[1].res);
    check("post_flush_tag", 32'(bus.out_tag), 32'(vecs[1].tag));
    @(posedge clk); #2; check("post_flush_empty", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset while a result is held.
    @(posedge clk); #1; bus.out_ready = 1'b0; present(vecs[6]);
    @(posedge clk); #1; bus.in_valid = 1'b0;
    @(posedge clk); #2; check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_res", bus.out_res, 32'h0);
    check("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk); rst = 1'b0; bus.out_ready = 1'b1;
    #1; check("rel_in_ready", 32'(bus.in_ready), 32'd1);
    check("rel_out_valid", 32'(bus.out_valid), 32'd0);
    run_stream(2, 1, 1000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
